mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline register of the 5-stage RISC-V core.
- Captures the memory-stage ALU result, the load data, the destination register and the writeback control bits on each rising clock edge, and presents them to the writeback stage.
- Also provides the muxed writeback data word, so the register file and forwarding unit share one source.

Parameters:
- XLEN, 32, data path width of result and load data.
- REG_ADDR_W, 5, register-index width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
- stall_mem_wb  input  1  1 = hold all registered outputs this cycle.
- flush_mem_wb  input  1  1 = load a bubble this cycle.
- result_in_mem_wb  input  XLEN  ALU result from the MEM stage.
- read_data_in_mem_wb  input  XLEN  data-memory load data.
- mem_to_reg_in_mem_wb  input  1  1 = writeback selects load data.
- rd_in_mem_wb  input  REG_ADDR_W  destination register index.
- reg_write_in_mem_wb  input  1  register-file write enable.
- result_out_mem_wb  output  XLEN  registered result.
- read_data_out_mem_wb  output  XLEN  registered load data.
- mem_to_reg_out_mem_wb  output  1  registered select.
- rd_out_mem_wb  output  REG_ADDR_W  registered destination index.
- reg_write_out_mem_wb  output  1  registered write enable.
- wb_data_mem_wb  output  XLEN  read_data_out if mem_to_reg_out = 1, else result_out.

Behaviour:
- Reset
  - rst = 0 immediately forces every registered output to 0, independent of clk.
  - Consequently wb_data = 0 while in reset.
  - Registers stay 0 while rst = 0.
  - The first capture occurs on the first rising edge with rst = 1.
- Latency: one cycle. Inputs sampled at rising edge N appear on the outputs just after edge N and are held until the next update.
- Priority at each rising edge (rst = 1):
  - flush = 1: all five registered outputs become 0 (bubble: reg_write = 0, rd = 0).
  - Else stall = 1: all outputs hold their current values.
  - Else: all outputs load their corresponding inputs.
  - Flush wins over a simultaneous stall.
- wb_data_mem_wb
  - Purely combinational from the registered outputs; no extra latency.
  - Changes only when the registers change.
- Pass-through rules
  - rd = 0 with reg_write = 1 passes unchanged; the register file ignores writes to x0.
  - Data fields are not masked or modified; full XLEN width is passed through.
- No handshake. The stage always accepts its inputs unless stalled.
- Reset asserted mid-operation clears outputs asynchronously. Captured data is lost; no recovery state exists.

Decomposition:
- Shared package (riscv_pkg): XLEN, REG_ADDR_W, and a struct mem_wb_t bundling result, read_data, mem_to_reg, rd and reg_write, reusable by the hazard and forwarding units.
- One natural sub-module: pipe_reg.
  - Generic width-parameterised register with asynchronous active-low reset, enable (not stall) and synchronous clear (flush).
  - Instantiated once over the packed mem_wb_t.
- The writeback mux stays in the top level.

Test Plan:
- Reset: drive rst = 0 with nonzero inputs (result 0xAAAA_BBBB, rd 10, reg_write 1) -> all outputs and wb_data = 0 with no clock edge needed; they stay 0 across edges while rst = 0.
- Capture with load select: rst = 1, inputs result 0xAAAA_BBBB, read_data 0x1111_2222, mem_to_reg 1, rd 10, reg_write 1 -> after one edge, outputs equal the inputs and wb_data = 0x1111_2222.
- Capture with ALU select: same data, mem_to_reg 0, rd 5 -> after one edge, wb_data = 0xAAAA_BBBB and rd_out = 5.
- Stall: registers hold the previous capture; assert stall, change inputs to result 0x1234_5678, rd 3 -> outputs unchanged for each stalled edge; the new values load on the first edge after stall deasserts.
- Flush priority: with valid data held, assert stall and flush together -> after one edge, all outputs 0, reg_write_out 0, wb_data 0.
- Asynchronous reset mid-operation: outputs nonzero; pull rst low between edges -> outputs 0 immediately (before the next edge); release rst -> next edge captures current inputs.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline types: datapath widths and the MEM/WB bundle.
// No logic; consumed by the pipeline register, hazard and forwarding units.
// Field order of mem_wb_t is fixed so packed slices stay stable across users.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    // Everything the writeback stage needs from one retiring instruction.
    typedef struct packed {
        logic [XLEN-1:0]       result;
        logic [XLEN-1:0]       read_data;
        logic                  mem_to_reg;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
    } mem_wb_t;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register with async clear, sync clear and load enable.
// Latency: one cycle from i_d to o_q.
// Backpressure: i_en = 0 holds the current value; i_clr overrides i_en.
module pipe_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,     // active-low, asynchronous
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Clear (async reset or sync clear) beats load; no enable means hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register plus the shared writeback data mux.
// Latency: one cycle for all registered fields; wb_data is combinational off the registers.
// Backpressure: stall holds every field, flush inserts a bubble and wins over stall.
module mem_wb_stage
    import riscv_pkg::*;
#(
    // Must match the package widths, since the bundle type comes from there.
    parameter int XLEN       = riscv_pkg::XLEN,
    parameter int REG_ADDR_W = riscv_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_mem_wb,
    input  logic                  flush_mem_wb,
    input  logic [XLEN-1:0]       result_in_mem_wb,
    input  logic [XLEN-1:0]       read_data_in_mem_wb,
    input  logic                  mem_to_reg_in_mem_wb,
    input  logic [REG_ADDR_W-1:0] rd_in_mem_wb,
    input  logic                  reg_write_in_mem_wb,
    output logic [XLEN-1:0]       result_out_mem_wb,
    output logic [XLEN-1:0]       read_data_out_mem_wb,
    output logic                  mem_to_reg_out_mem_wb,
    output logic [REG_ADDR_W-1:0] rd_out_mem_wb,
    output logic                  reg_write_out_mem_wb,
    output logic [XLEN-1:0]       wb_data_mem_wb
);

    mem_wb_t w_d;
    mem_wb_t w_q;
    logic    w_load_en;

    // Bundle the MEM-stage fields; data is passed untouched, rd = 0 included.
    always_comb begin
        w_d            = '0;
        w_d.result     = result_in_mem_wb;
        w_d.read_data  = read_data_in_mem_wb;
        w_d.mem_to_reg = mem_to_reg_in_mem_wb;
        w_d.rd         = rd_in_mem_wb;
        w_d.reg_write  = reg_write_in_mem_wb;
    end

    assign w_load_en = ~stall_mem_wb;

    pipe_reg #(
        .WIDTH ($bits(mem_wb_t))
    ) u_pipe_reg (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_load_en),
        .i_clr (flush_mem_wb),
        .i_d   (w_d),
        .o_q   (w_q)
    );

    assign result_out_mem_wb     = w_q.result;
    assign read_data_out_mem_wb  = w_q.read_data;
    assign mem_to_reg_out_mem_wb = w_q.mem_to_reg;
    assign rd_out_mem_wb         = w_q.rd;
    assign reg_write_out_mem_wb  = w_q.reg_write;

    // One writeback source for both the register file and the forwarding unit.
    assign wb_data_mem_wb = w_q.mem_to_reg ? w_q.read_data : w_q.result;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] res_in;
    logic [31:0] rdd_in;
    logic        m2r_in;
    logic [4:0]  rd_in;
    logic        rw_in;
    logic [31:0] res_out;
    logic [31:0] rdd_out;
    logic        m2r_out;
    logic [4:0]  rd_out;
    logic        rw_out;
    logic [31:0] wb_out;

    int errors = 0;
    int checks = 0;

    mem_wb_stage dut (
        .clk                   (clk),
        .rst                   (rst),
        .stall_mem_wb          (stall),
        .flush_mem_wb          (flush),
        .result_in_mem_wb      (res_in),
        .read_data_in_mem_wb   (rdd_in),
        .mem_to_reg_in_mem_wb  (m2r_in),
        .rd_in_mem_wb          (rd_in),
        .reg_write_in_mem_wb   (rw_in),
        .result_out_mem_wb     (res_out),
        .read_data_out_mem_wb  (rdd_out),
        .mem_to_reg_out_mem_wb (m2r_out),
        .rd_out_mem_wb         (rd_out),
        .reg_write_out_mem_wb  (rw_out),
        .wb_data_mem_wb        (wb_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One instruction as the writeback stage sees it.
    typedef struct {
        logic [31:0] res;
        logic [31:0] rdd;
        logic        m2r;
        logic [4:0]  rd;
        logic        rw;
    } instr_t;

    typedef struct {
        logic   stall;
        logic   flush;
        instr_t in;
        instr_t exp;
        logic [31:0] exp_wb;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input instr_t e, input logic [31:0] ewb);
        chk({tag, " result"},    res_out,        e.res);
        chk({tag, " read_data"}, rdd_out,        e.rdd);
        chk({tag, " mem_to_reg"}, {31'd0, m2r_out}, {31'd0, e.m2r});
        chk({tag, " rd"},        {27'd0, rd_out},  {27'd0, e.rd});
        chk({tag, " reg_write"}, {31'd0, rw_out},  {31'd0, e.rw});
        chk({tag, " wb_data"},   wb_out,         ewb);
    endtask

    task automatic drive(input logic st, input logic fl, input instr_t i);
        stall  = st;
        flush  = fl;
        res_in = i.res;
        rdd_in = i.rdd;
        m2r_in = i.m2r;
        rd_in  = i.rd;
        rw_in  = i.rw;
    endtask

    // Drive mid-cycle, then sample just after the capturing edge.
    task automatic step(input logic st, input logic fl, input instr_t i);
        @(negedge clk);
        drive(st, fl, i);
        @(posedge clk);
        #1;
    endtask

    function automatic instr_t mk(input logic [31:0] r, input logic [31:0] d,
                                  input logic m, input logic [4:0] a, input logic w);
        instr_t t;
        t.res = r; t.rdd = d; t.m2r = m; t.rd = a; t.rw = w;
        return t;
    endfunction

    function automatic logic [31:0] wb_of(input instr_t t);
        return t.m2r ? t.rdd : t.res;
    endfunction

    vec_t   vecs[8];
    instr_t zero_i;
    instr_t held;
    instr_t cur;

    initial begin
        zero_i = mk(32'h0, 32'h0, 1'b0, 5'd0, 1'b0);

        // Stateful sequence: each row is one clock edge, expected values worked out by hand.
        vecs[0] = '{1'b0, 1'b0, mk(32'hAAAA_BBBB, 32'h1111_2222, 1'b1, 5'd10, 1'b1),
                               mk(32'hAAAA_BBBB, 32'h1111_2222, 1'b1, 5'd10, 1'b1), 32'h1111_2222};
        vecs[1] = '{1'b0, 1'b0, mk(32'hAAAA_BBBB, 32'h1111_2222, 1'b0, 5'd5, 1'b1),
                               mk(32'hAAAA_BBBB, 32'h1111_2222, 1'b0, 5'd5, 1'b1), 32'hAAAA_BBBB};
        vecs[2] = '{1'b1, 1'b0, mk(32'h1234_5678, 32'h1111_2222, 1'b0, 5'd3, 1'b1),
                               mk(32'hAAAA_BBBB, 32'h1111_2222, 1'b0, 5'd5, 1'b1), 32'hAAAA_BBBB};
        vecs[3] = '{1'b1, 1'b0, mk(32'h1234_5678, 32'h1111_2222, 1'b0, 5'd3, 1'b1),
                               mk(32'hAAAA_BBBB, 32'h1111_2222, 1'b0, 5'd5, 1'b1), 32'hAAAA_BBBB};
        vecs[4] = '{1'b0, 1'b0, mk(32'h1234_5678, 32'h1111_2222, 1'b0, 5'd3, 1'b1),
                               mk(32'h1234_5678, 32'h1111_2222, 1'b0, 5'd3, 1'b1), 32'h1234_5678};
        vecs[5] = '{1'b1, 1'b1, mk(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 5'd31, 1'b1),
                               mk(32'h0, 32'h0, 1'b0, 5'd0, 1'b0), 32'h0};
        vecs[6] = '{1'b0, 1'b0, mk(32'hFFFF_FFFF, 32'h8000_0001, 1'b1, 5'd0, 1'b1),
                               mk(32'hFFFF_FFFF, 32'h8000_0001, 1'b1, 5'd0, 1'b1), 32'h8000_0001};
        vecs[7] = '{1'b0, 1'b1, mk(32'h5555_5555, 32'h6666_6666, 1'b1, 5'd7, 1'b1),
                               mk(32'h0, 32'h0, 1'b0, 5'd0, 1'b0), 32'h0};

        // Reset asserted with live inputs: outputs must be zero before any edge.
        rst = 1'b0;
        drive(1'b0, 1'b0, mk(32'hAAAA_BBBB, 32'h1111_2222, 1'b1, 5'd10, 1'b1));
        #1;
        chk_all("reset_no_edge", zero_i, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset_held", zero_i, 32'h0);

        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            step(vecs[i].stall, vecs[i].flush, vecs[i].in);
            chk_all($sformatf("vec%0d", i), vecs[i].exp, vecs[i].exp_wb);
        end

        // Mid-operation async reset: capture, then drop rst between edges.
        cur = mk(32'h0BAD_F00D, 32'h7777_8888, 1'b0, 5'd12, 1'b1);
        step(1'b0, 1'b0, cur);
        chk_all("pre_async", cur, 32'h0BAD_F00D);
        #2;
        rst = 1'b0;
        #1;
        chk_all("async_clear", zero_i, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        cur = mk(32'h1357_9BDF, 32'h2468_ACE0, 1'b1, 5'd9, 1'b1);
        drive(1'b0, 1'b0, cur);
        #1;
        chk_all("released_before_edge", zero_i, 32'h0);
        @(posedge clk);
        #1;
        chk_all("first_after_release", cur, 32'h2468_ACE0);

        // Random traffic against a model of the last accepted instruction.
        held = cur;
        for (int n = 0; n < 300; n++) begin
            logic st, fl;
            instr_t r;
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 7) == 0);
            r  = mk($urandom, $urandom, 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            step(st, fl, r);
            if (fl)       held = zero_i;
            else if (!st) held = r;
            chk_all($sformatf("rand%0d", n), held, wb_of(held));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
